// File: rtl/gbif_pkg.sv
// gbif_pkg: shared definitions for the GBIF transfer sequencer.
//   - gbif_state_e : sequencer FSM states
//   - LEN_*_DEF    : default burst lengths per transfer class
//   - CNT_W        : width of beat and watchdog counters
//   - type_dir()   : transfer type -> direction (1 = host to chip)
//   - type_len()   : transfer type -> burst length
package gbif_pkg;

  localparam int CNT_W         = 10;
  localparam int LEN_SHORT_DEF = 64;
  localparam int LEN_WADDR_DEF = 54;
  localparam int LEN_LONG_DEF  = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } gbif_state_e;

  // Types 1 and 2 move data chip->host; every other type reads into the chip.
  function automatic logic type_dir(input logic [2:0] t);
    return !((t == 3'd1) || (t == 3'd2));
  endfunction

  function automatic logic [CNT_W-1:0] type_len(input logic [2:0] t,
                                                 input int len_short,
                                                 input int len_waddr,
                                                 input int len_long);
    logic [CNT_W-1:0] len;
    case (t)
      3'd0, 3'd1, 3'd2: len = CNT_W'(len_short);
      3'd3:             len = CNT_W'(len_waddr);
      default:          len = CNT_W'(len_long);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/gbif_skid2.sv
// gbif_skid2: two-entry skid buffer with a registered input ready.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : drop all stored beats and deassert ready
//   accept_en         : upstream may be offered ready on the next cycle
//   in_val/in_rdy     : input beat handshake (in_rdy is a flop)
//   in_data           : input beat
//   out_val/out_rdy   : output beat handshake (out_val, out_data are flops)
//   out_data          : head-of-buffer beat
// Ready is recomputed from the next occupancy, so the second entry absorbs
// the beat that can still arrive in the cycle after the far side stalls.
module gbif_skid2 #(
  parameter int PORT_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  accept_en,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [PORT_WIDTH-1:0] in_data,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [PORT_WIDTH-1:0] out_data
);

  logic [1:0]            cnt_q;
  logic [1:0]            cnt_nxt;
  logic                  rdy_q;
  logic [PORT_WIDTH-1:0] data_p0;
  logic [PORT_WIDTH-1:0] data_p1;
  logic                  push;
  logic                  pop;

  assign in_rdy   = rdy_q;
  assign out_val  = (cnt_q != 2'd0);
  assign out_data = data_p0;
  assign push     = in_val & rdy_q;
  assign pop      = out_val & out_rdy;

  always_comb begin
    cnt_nxt = cnt_q;
    if (push && !pop) begin
      cnt_nxt = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_nxt = cnt_q - 2'd1;
    end
  end

  // Storage stage: data_p0 is the head presented downstream, data_p1 the skid slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      rdy_q   <= 1'b0;
      data_p0 <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      rdy_q <= accept_en && (cnt_nxt <= 2'd1);
      if (pop) begin
        if (push && (cnt_q == 2'd1)) begin
          data_p0 <= in_data;
        end else begin
          data_p0 <= data_p1;
        end
        if (push && (cnt_q == 2'd2)) begin
          data_p1 <= in_data;
        end
      end else if (push) begin
        if (cnt_q == 2'd0) begin
          data_p0 <= in_data;
        end else begin
          data_p1 <= in_data;
        end
      end
    end
  end

endmodule

// File: rtl/gbif_xfer_seq.sv
// gbif_xfer_seq: GBIF on-chip transfer sequencer.
// One request becomes a config handshake ({type, dir} on cfg_info), a burst
// of beats in the direction implied by the type, and a one-cycle done pulse.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_val/req_rdy, req_type  : internal request
//   cfg_val/cfg_rdy, cfg_info  : config handshake towards the host
//   rd_val/rd_rdy, rd_data     : host->chip beats
//   wr_val/wr_rdy, wr_data     : chip->host beats
//   buf_val/buf_rdy, buf_data, buf_last : received beats to the global buffer
//   src_val/src_rdy, src_data  : outgoing beats from the global buffer
//   io_drive                   : chip drives the shared pad bus (CFG, WR)
//   busy, done, err            : status; err only with the watchdog build
// Build option: define GBIF_TIMEOUT_EN to enable the 1023-cycle idle watchdog.
module gbif_xfer_seq
  import gbif_pkg::*;
#(
  parameter int PORT_WIDTH = 128,
  parameter int LEN_SHORT  = LEN_SHORT_DEF,
  parameter int LEN_WADDR  = LEN_WADDR_DEF,
  parameter int LEN_LONG   = LEN_LONG_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic [2:0]            req_type,
  output logic                  cfg_val,
  input  logic                  cfg_rdy,
  output logic [3:0]            cfg_info,
  input  logic                  rd_val,
  output logic                  rd_rdy,
  input  logic [PORT_WIDTH-1:0] rd_data,
  output logic                  wr_val,
  input  logic                  wr_rdy,
  output logic [PORT_WIDTH-1:0] wr_data,
  output logic                  buf_val,
  input  logic                  buf_rdy,
  output logic [PORT_WIDTH-1:0] buf_data,
  output logic                  buf_last,
  input  logic                  src_val,
  output logic                  src_rdy,
  input  logic [PORT_WIDTH-1:0] src_data,
  output logic                  io_drive,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  gbif_state_e           state_q;
  gbif_state_e           state_nxt;
  logic [3:0]            cfg_info_q;
  logic                  req_rdy_q;
  logic [CNT_W-1:0]      cnt_in_q;
  logic [CNT_W-1:0]      cnt_out_q;
  logic [CNT_W-1:0]      cnt_in_nxt;
  logic [CNT_W-1:0]      len_cur;
  logic [CNT_W-1:0]      len_m1;
  logic                  dir;
  logic                  req_hs;
  logic                  cfg_hs;
  logic                  push;
  logic                  pop;
  logic                  last_in;
  logic                  last_out;
  logic                  accept_en;
  logic                  timeout;
  logic                  sk_in_val;
  logic                  sk_in_rdy;
  logic                  sk_out_val;
  logic                  sk_out_rdy;
  logic [PORT_WIDTH-1:0] sk_in_data;
  logic [PORT_WIDTH-1:0] sk_out_data;

  assign dir      = cfg_info_q[0];
  assign len_cur  = type_len(cfg_info_q[3:1], LEN_SHORT, LEN_WADDR, LEN_LONG);
  assign len_m1   = len_cur - CNT_W'(1);
  assign req_hs   = req_val && req_rdy_q && (state_q == ST_IDLE);
  assign cfg_hs   = (state_q == ST_CFG) && cfg_rdy;
  assign push     = sk_in_val & sk_in_rdy;
  assign pop      = sk_out_val & sk_out_rdy;
  assign last_in  = push && (cnt_in_q == len_m1);
  assign last_out = pop && (cnt_out_q == len_m1);

  // The single skid buffer is steered by direction: rd->buf or src->wr.
  assign sk_in_val  = dir ? rd_val  : src_val;
  assign sk_in_data = dir ? rd_data : src_data;
  assign sk_out_rdy = dir ? buf_rdy : wr_rdy;
  assign rd_rdy     = sk_in_rdy &  dir;
  assign src_rdy    = sk_in_rdy & ~dir;
  assign buf_val    = sk_out_val &  dir;
  assign wr_val     = sk_out_val & ~dir;
  assign buf_data   = sk_out_data;
  assign wr_data    = sk_out_data;
  assign buf_last   = buf_val && (cnt_out_q == len_m1);
  assign cfg_info   = cfg_info_q;
  assign req_rdy    = req_rdy_q;

  // Ready for the skid is decided one cycle ahead; stop offering it once
  // len beats have entered so no extra beat is ever taken.
  assign cnt_in_nxt = cnt_in_q + CNT_W'(push);
  assign accept_en  = !timeout &&
                      ((state_nxt == ST_RD) || (state_nxt == ST_WR)) &&
                      (cnt_in_nxt < len_cur);

  gbif_skid2 #(
    .PORT_WIDTH (PORT_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (timeout),
    .accept_en (accept_en),
    .in_val    (sk_in_val),
    .in_rdy    (sk_in_rdy),
    .in_data   (sk_in_data),
    .out_val   (sk_out_val),
    .out_rdy   (sk_out_rdy),
    .out_data  (sk_out_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (req_hs) state_nxt = ST_CFG;
      ST_CFG:   if (cfg_hs) state_nxt = dir ? ST_RD : ST_WR;
      ST_RD:    if (last_in) state_nxt = ST_DRAIN;
      ST_WR:    if (last_out) state_nxt = ST_DONE;
      // Leave as the last beat is taken by the buffer, not a cycle later.
      ST_DRAIN: if (last_out || (cnt_out_q == len_cur)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (timeout) begin
      state_nxt = ST_DONE;
    end
  end

  // State-decoded outputs
  always_comb begin
    cfg_val  = 1'b0;
    io_drive = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_CFG: begin
        cfg_val  = 1'b1;
        io_drive = 1'b1;
      end
      ST_WR:   io_drive = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Request latch and beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rdy_q  <= 1'b0;
      cfg_info_q <= 4'd0;
      cnt_in_q   <= '0;
      cnt_out_q  <= '0;
    end else begin
      req_rdy_q <= (state_nxt == ST_IDLE);
      if (req_hs) begin
        cfg_info_q <= {req_type, type_dir(req_type)};
        cnt_in_q   <= '0;
        cnt_out_q  <= '0;
      end else begin
        cnt_in_q <= cnt_in_nxt;
        if (pop) begin
          cnt_out_q <= cnt_out_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef GBIF_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt_q;
  logic             err_q;
  logic             active;
  logic             any_hs;

  assign active  = (state_q == ST_CFG) || (state_q == ST_RD) ||
                   (state_q == ST_WR)  || (state_q == ST_DRAIN);
  assign any_hs  = cfg_hs | push | pop;
  assign timeout = active && (idle_cnt_q == '1);
  assign err     = err_q;

  // Watchdog: err lines up with the done cycle that the timeout forces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= timeout;
      if (!active || any_hs) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_gbif_xfer_seq.sv
// tb_gbif_xfer_seq: table-driven bench for gbif_xfer_seq.
// Each table row is one transfer: type, expected cfg_info, expected length,
// config delay, host/buffer handshake gaps, an optional buffer stall and an
// optional mid-burst reset point.
module tb_gbif_xfer_seq;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_val = 1'b0;
  logic         req_rdy;
  logic [2:0]   req_type = 3'd0;
  logic         cfg_val;
  logic         cfg_rdy = 1'b0;
  logic [3:0]   cfg_info;
  logic         rd_val = 1'b0;
  logic         rd_rdy;
  logic [W-1:0] rd_data = '0;
  logic         wr_val;
  logic         wr_rdy = 1'b0;
  logic [W-1:0] wr_data;
  logic         buf_val;
  logic         buf_rdy = 1'b0;
  logic [W-1:0] buf_data;
  logic         buf_last;
  logic         src_val = 1'b0;
  logic         src_rdy;
  logic [W-1:0] src_data = '0;
  logic         io_drive;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gbif_xfer_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_type (req_type),
    .cfg_val  (cfg_val),
    .cfg_rdy  (cfg_rdy),
    .cfg_info (cfg_info),
    .rd_val   (rd_val),
    .rd_rdy   (rd_rdy),
    .rd_data  (rd_data),
    .wr_val   (wr_val),
    .wr_rdy   (wr_rdy),
    .wr_data  (wr_data),
    .buf_val  (buf_val),
    .buf_rdy  (buf_rdy),
    .buf_data (buf_data),
    .buf_last (buf_last),
    .src_val  (src_val),
    .src_rdy  (src_rdy),
    .src_data (src_data),
    .io_drive (io_drive),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic [2:0] typ;
    logic [3:0] info;
    int         len;
    int         cfg_delay;
    int         val_gap;
    int         rdy_gap;
    int         stall_at;
    int         abort_at;
  } vec_t;

  vec_t vecs [9];

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] beat(input int tag, input int idx);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    a = 32'hC0DE0000 ^ 32'(tag);
    b = 32'(idx);
    c = 32'(idx * 7 + tag);
    return {a, b, ~b, c};
  endfunction

  function automatic logic act(input int gap, input int cyc);
    return (gap == 0) || ((cyc % gap) != 0);
  endfunction

  task automatic chk_all_zero(input string nm);
    chk_b({nm, "_req_rdy"}, req_rdy, 1'b0);
    chk_b({nm, "_cfg_val"}, cfg_val, 1'b0);
    chk_i({nm, "_cfg_info"}, int'(cfg_info), 0);
    chk_b({nm, "_rd_rdy"}, rd_rdy, 1'b0);
    chk_b({nm, "_wr_val"}, wr_val, 1'b0);
    chk_w({nm, "_wr_data"}, wr_data, '0);
    chk_b({nm, "_buf_val"}, buf_val, 1'b0);
    chk_w({nm, "_buf_data"}, buf_data, '0);
    chk_b({nm, "_buf_last"}, buf_last, 1'b0);
    chk_b({nm, "_src_rdy"}, src_rdy, 1'b0);
    chk_b({nm, "_io_drive"}, io_drive, 1'b0);
    chk_b({nm, "_busy"}, busy, 1'b0);
    chk_b({nm, "_done"}, done, 1'b0);
    chk_b({nm, "_err"}, err, 1'b0);
  endtask

  task automatic start_req(input logic [2:0] t);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk_b("req_rdy_idle", req_rdy, 1'b1);
    req_type = t;
    req_val  = 1'b1;
    @(negedge clk);
    req_val  = 1'b0;
    req_type = 3'd0;
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    int   cyc, rd_sent, buf_got, src_sent, wr_got, done_cnt;
    int   first_hs, last_hs, last_out_cyc, done_cyc, stall_start;
    logic dir;
    logic wr_stall_prev;
    logic [W-1:0] wr_prev;
    dir = v.info[0];
    cyc = 0; rd_sent = 0; buf_got = 0; src_sent = 0; wr_got = 0; done_cnt = 0;
    first_hs = -1; last_hs = -1; last_out_cyc = -1; done_cyc = -1; stall_start = -1;
    wr_stall_prev = 1'b0;
    wr_prev = '0;

    start_req(v.typ);
    chk_b("cfg_val_latency", cfg_val, 1'b1);
    chk_i("cfg_info", int'(cfg_info), int'(v.info));
    chk_b("io_drive_cfg", io_drive, 1'b1);
    chk_b("busy_cfg", busy, 1'b1);
    for (int i = 0; i < v.cfg_delay; i++) begin
      @(negedge clk);
      chk_b("cfg_val_hold", cfg_val, 1'b1);
      chk_i("cfg_info_hold", int'(cfg_info), int'(v.info));
    end
    cfg_rdy = 1'b1;
    @(negedge clk);
    cfg_rdy = 1'b0;
    chk_b("cfg_val_after_hs", cfg_val, 1'b0);

    while (cyc < 3000) begin
      if (v.stall_at >= 0 && stall_start < 0 && buf_got == v.stall_at) stall_start = cyc;
      rd_val   = dir && ((rd_sent >= v.len) || act(v.val_gap, cyc));
      rd_data  = beat(tag, rd_sent);
      src_val  = !dir;
      src_data = beat(tag, src_sent);
      buf_rdy  = act(v.rdy_gap, cyc) && !(stall_start >= 0 && cyc < stall_start + 10);
      wr_rdy   = act(v.rdy_gap, cyc);
      #1;
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        done_cnt++;
        chk_b("req_rdy_in_done", req_rdy, 1'b0);
        chk_b("err_normal", err, 1'b0);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk_b("busy_after_done", busy, 1'b0);
        chk_b("req_rdy_after_done", req_rdy, 1'b1);
      end
      if (stall_start >= 0 && (cyc == stall_start + 2 || cyc == stall_start + 9))
        chk_b("rd_rdy_stall", rd_rdy, 1'b0);
      if (dir && rd_sent >= v.len && cyc > last_hs)
        chk_b("rd_rdy_after_len", rd_rdy, 1'b0);
      if (rd_val && rd_rdy) begin
        chk_b("io_drive_rd", io_drive, 1'b0);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        rd_sent++;
        if (v.abort_at >= 0 && rd_sent == v.abort_at) begin
          #1;
          rst_n = 1'b0;
          #1;
          chk_all_zero("abort");
          @(negedge clk);
          rst_n   = 1'b1;
          rd_val  = 1'b0;
          buf_rdy = 1'b0;
          wr_rdy  = 1'b0;
          src_val = 1'b0;
          return;
        end
      end
      if (buf_val && buf_rdy) begin
        chk_w("buf_data", buf_data, beat(tag, buf_got));
        chk_b("buf_last", buf_last, buf_got == v.len - 1);
        buf_got++;
        last_out_cyc = cyc;
      end
      if (src_val && src_rdy) src_sent++;
      if (wr_stall_prev) begin
        chk_b("wr_val_held", wr_val, 1'b1);
        chk_w("wr_data_stable", wr_data, wr_prev);
      end
      if (wr_val && wr_rdy) begin
        chk_b("io_drive_wr", io_drive, 1'b1);
        chk_w("wr_data", wr_data, beat(tag, wr_got));
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        wr_got++;
        last_out_cyc = cyc;
      end
      wr_stall_prev = wr_val && !wr_rdy;
      wr_prev = wr_data;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
      cyc++;
    end

    rd_val = 1'b0; src_val = 1'b0; buf_rdy = 1'b0; wr_rdy = 1'b0;
    chk_b("done_seen", done_cyc >= 0, 1'b1);
    chk_i("done_count", done_cnt, 1);
    chk_i("beats_out", dir ? buf_got : wr_got, v.len);
    chk_i("beats_in", dir ? rd_sent : src_sent, v.len);
    if (done_cyc >= 0) chk_i("done_latency", done_cyc - last_out_cyc, 1);
    if (v.val_gap == 0 && v.rdy_gap == 0 && v.stall_at < 0)
      chk_i("full_rate", last_hs - first_hs, v.len - 1);
  endtask

  initial begin
    vecs[0] = '{3'd0, 4'b0001,  64, 3, 3, 0,  -1, -1};
    vecs[1] = '{3'd2, 4'b0100,  64, 1, 0, 2,  -1, -1};
    vecs[2] = '{3'd1, 4'b0010,  64, 0, 0, 0,  -1, -1};
    vecs[3] = '{3'd3, 4'b0111,  54, 2, 0, 0,  -1, -1};
    vecs[4] = '{3'd6, 4'b1101, 512, 0, 0, 0, 100, -1};
    vecs[5] = '{3'd5, 4'b1011, 512, 1, 0, 3,  -1, -1};
    vecs[6] = '{3'd4, 4'b1001, 512, 0, 0, 0,  -1, 30};
    vecs[7] = '{3'd0, 4'b0001,  64, 0, 0, 0,  -1, -1};
    vecs[8] = '{3'd7, 4'b1111, 512, 0, 2, 0,  -1, -1};

    rst_n = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_b("req_rdy_after_reset", req_rdy, 1'b1);

    for (int k = 0; k < 9; k++) begin
      run_vec(vecs[k], 16 * k + int'(vecs[k].typ));
    end

`ifdef GBIF_TIMEOUT_EN
    begin
      int n;
      start_req(3'd0);
      n = 0;
      while (!done && n < 1200) begin
        @(negedge clk);
        n++;
      end
      chk_b("timeout_done", done, 1'b1);
      chk_b("timeout_err", err, 1'b1);
      chk_b("timeout_cycles", (n >= 1020) && (n <= 1026), 1'b1);
      @(negedge clk);
      chk_b("timeout_idle", busy, 1'b0);
      chk_b("timeout_err_pulse", err, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
